// File: rtl/xif_mem_responder.sv
// xif_mem_responder
// Core-side memory responder for the CORE-V-XIF memory request/response and
// memory result interfaces. Services FLW/FSW-style accesses from an internal
// word memory. mem_resp is combinational in the handshake cycle. mem_result
// is a one-cycle strobe issued in order, RESP_LATENCY cycles after the accept.
//
// Ports
//   ck, rst            clock (rising edge), asynchronous active-high reset
//   stall              back-pressure; forces mem_ready low
//   mem_valid/ready    request handshake
//   mem_req_*          request fields (mode/last/spec/attr are ignored)
//   mem_resp_*         exception response, valid only in the handshake cycle
//   mem_result_*       in-order completion strobe with load data
//   bd_we/addr/wdata   backdoor full-word write used for preloading
module xif_mem_responder #(
  parameter int unsigned X_ID_WIDTH   = 4,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned X_MEM_WIDTH  = 32,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned RESP_LATENCY = 2
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [X_ID_WIDTH-1:0]        mem_req_id,
  input  logic [XLEN-1:0]              mem_req_addr,
  input  logic [1:0]                   mem_req_mode,
  input  logic                         mem_req_we,
  input  logic [2:0]                   mem_req_size,
  input  logic [X_MEM_WIDTH/8-1:0]     mem_req_be,
  input  logic [X_MEM_WIDTH-1:0]       mem_req_wdata,
  input  logic                         mem_req_last,
  input  logic                         mem_req_spec,
  input  logic [1:0]                   mem_req_attr,
  output logic                         mem_resp_exc,
  output logic [5:0]                   mem_resp_exccode,
  output logic                         mem_resp_dbg,
  output logic                         mem_result_valid,
  output logic [X_ID_WIDTH-1:0]        mem_result_id,
  output logic [X_MEM_WIDTH-1:0]       mem_result_rdata,
  output logic                         mem_result_err,
  output logic                         mem_result_dbg,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [31:0]                  bd_wdata
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned LANES = X_MEM_WIDTH / 8;
  localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(64'(MEM_WORDS) * 4);

  logic [X_MEM_WIDTH-1:0] mem [MEM_WORDS];

  logic                   ready_q;
  logic                   handshake;
  logic                   accept;
  logic                   fault;
  logic [5:0]             code;
  logic [AW-1:0]          word_idx;
  logic [X_MEM_WIDTH-1:0] rd_word;
  logic [X_MEM_WIDTH-1:0] shifted;
  logic [X_MEM_WIDTH-1:0] load_data;

  logic                   pipe_valid [RESP_LATENCY];
  logic [X_ID_WIDTH-1:0]  pipe_id    [RESP_LATENCY];
  logic [X_MEM_WIDTH-1:0] pipe_data  [RESP_LATENCY];

  logic unused_ok;
  assign unused_ok = ^{mem_req_mode, mem_req_last, mem_req_spec, mem_req_attr};

  assign mem_ready = ready_q && !stall;
  assign handshake = mem_valid && mem_ready;
  assign word_idx  = mem_req_addr[AW+1:2];

  // Checks are ordered: illegal size, then alignment, then address range.
  always_comb begin
    fault = 1'b0;
    code  = '0;
    if (mem_req_size > 3'd2) begin
      fault = 1'b1;
      code  = mem_req_we ? 6'd7 : 6'd5;
    end else if ((mem_req_size == 3'd1 && mem_req_addr[0]) ||
                 (mem_req_size == 3'd2 && mem_req_addr[1:0] != 2'b00)) begin
      fault = 1'b1;
      code  = mem_req_we ? 6'd6 : 6'd4;
    end else if ({1'b0, mem_req_addr} >= ADDR_LIMIT) begin
      fault = 1'b1;
      code  = mem_req_we ? 6'd7 : 6'd5;
    end
  end

  assign mem_resp_exc     = handshake && fault;
  assign mem_resp_exccode = mem_resp_exc ? code : '0;
  assign mem_resp_dbg     = 1'b0;
  assign accept           = handshake && !fault;

  // Load data is taken from the pre-edge memory contents, right-justified.
  always_comb begin
    rd_word   = mem[word_idx];
    shifted   = rd_word >> {mem_req_addr[1:0], 3'b000};
    load_data = shifted;
    case (mem_req_size)
      3'd0:    load_data = X_MEM_WIDTH'(shifted[7:0]);
      3'd1:    load_data = X_MEM_WIDTH'(shifted[15:0]);
      default: load_data = shifted;
    endcase
  end

  // Memory is never reset. The backdoor write is issued last so it wins
  // over an accepted store to the same word on the same edge.
  always_ff @(posedge ck) begin
    if (accept && mem_req_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (mem_req_be[i]) mem[word_idx][8*i +: 8] <= mem_req_wdata[8*i +: 8];
      end
    end
    if (bd_we) mem[bd_addr] <= X_MEM_WIDTH'(bd_wdata);
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_id[i]    <= '0;
        pipe_data[i]  <= '0;
      end
    end else begin
      ready_q       <= 1'b1;
      pipe_valid[0] <= accept;
      pipe_id[0]    <= accept ? mem_req_id : '0;
      pipe_data[0]  <= (accept && !mem_req_we) ? load_data : '0;
      for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign mem_result_valid = pipe_valid[RESP_LATENCY-1];
  assign mem_result_id    = pipe_id[RESP_LATENCY-1];
  assign mem_result_rdata = pipe_data[RESP_LATENCY-1];
  assign mem_result_err   = 1'b0;
  assign mem_result_dbg   = 1'b0;

endmodule
